pi_pwm_drive: RTL and testbench
===============================

Name: pi_pwm_drive

Overview:
Downstream stage of the incremental PI speed controller. It integrates the controller's signed per-update delta into a saturated duty accumulator, then converts that duty into a fixed-frequency PWM and a direction signal for one motor H-bridge. Duty changes apply only at PWM period boundaries. A direction reversal inserts a dead interval, with PWM forced low, before the new direction is driven.

Parameters:
PERIOD, 3999, PWM counter terminal value; period = PERIOD+1 clk cycles.
DUTY_MAX, 3800, accumulator clamp magnitude in counts; must be <= PERIOD+1.
SHIFT, 7, arithmetic right shift applied to delta before accumulation.
DEAD_PERIODS, 1, number of whole PWM periods PWM is held low on a direction reversal; must be >= 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  one-cycle strobe, same strobe that updates the PI stage; delta is valid while enable is high
delta  in  32  signed incremental controller output (two's complement)
clear  in  1  synchronous accumulator clear (motor stop)
pwm  out  1  PWM drive to bridge
dir  out  1  direction; 0 = forward (acc > 0), 1 = reverse (acc < 0)
duty  out  16  active duty magnitude currently applied
sat  out  1  high while the accumulator is clamped at +/-DUTY_MAX

Behaviour:
- Clock and reset: all registers update on posedge clk; rst is synchronous and active-high.
- Reset values: acc=0, cnt=0, duty=0, dir=0, pwm=0, sat=0, state=RUN, dead_cnt=0. Asserting rst mid-period or mid-DEAD aborts immediately with these values.
- Accumulator (signed 32-bit acc):
  - clear has priority over enable; clear forces acc=0 and sat=0 next cycle.
  - On enable: sum = acc + (delta >>> SHIFT), computed at 33 bits so no wrap occurs.
  - Clamp: if sum > DUTY_MAX, acc=DUTY_MAX and sat=1; if sum < -DUTY_MAX, acc=-DUTY_MAX and sat=1; otherwise acc=sum and sat=0.
  - Latency: enable in cycle t gives new acc/sat visible in t+1. Without enable, acc holds.
- PWM counter:
  - cnt runs 0..PERIOD and wraps to 0. Free-running, unaffected by enable or clear.
  - Boundary = the cycle where cnt==PERIOD.
- pwm output: registered; pwm = (state==RUN) && (cnt_next < duty). The first cycle of a period therefore reflects the newly loaded duty. duty=0 gives constant low; duty=PERIOD+1 gives constant high.
- FSM, evaluated only at boundaries (mag=|acc|, sgn=acc<0):
  - RUN:
    - If mag==0: duty=0, dir unchanged.
    - Else if sgn==dir: duty=mag.
    - Else (reversal): duty=0, dir held, dead_cnt=DEAD_PERIODS, go DEAD.
  - DEAD: at each boundary dead_cnt decrements.
    - When it reaches 0, re-evaluate acc: if still reversed and mag!=0, dir=sgn, duty=mag, go RUN.
    - If acc returned to the old sign or zero, go RUN with duty=mag (or 0) and dir unchanged.
  - pwm is 0 for the whole DEAD state.
- dir never changes while pwm is high. dir changes only at a boundary, coincident with duty load.
- clear during DEAD does not shorten DEAD. At exit, mag==0 gives duty=0.
- Simultaneous enable and boundary: the boundary samples pre-update acc; the new acc applies at the next boundary.

Test Plan:
1. Reset then idle. With rst=1 for 2 cycles and enable=0 for 3 periods -> pwm=0, dir=0, duty=0, sat=0 throughout, and cnt wraps every 4000 cycles.
2. Single step (SHIFT=7). One enable with delta=128000 -> acc=1000 next cycle. At the following boundary duty=1000; pwm is high exactly 1000 of each 4000 cycles; dir=0.
3. Saturation. Five enables with delta=128000 -> acc clamps at 3800, sat=1, duty=3800. Then delta=-12800 -> acc=3700, sat=0.
4. Reversal. With acc=1000 and dir=0, apply delta=-256000 (acc=-1000) -> next boundary: duty=0, pwm low for one full period. Following boundary: dir=1, duty=1000.
5. Reversal cancelled. Same as 4, but during DEAD apply delta=+256000 (acc=1000) -> DEAD exit keeps dir=0, duty=1000.
6. Clear and priority. With acc=2000, assert clear and enable (delta=128000) in the same cycle -> acc=0, sat=0. Next boundary: duty=0, pwm=0, dir unchanged.

Source files
------------

// File: rtl/pi_pwm_drive.sv
// pi_pwm_drive: integrates the PI controller's signed per-update delta into a
// saturated duty accumulator. The duty is turned into a fixed-frequency PWM
// and a direction bit for one H-bridge. New duty values are loaded only at
// period boundaries. A direction reversal holds the PWM low for whole dead
// periods before the new direction is driven.
module pi_pwm_drive #(
  parameter int PERIOD       = 3999,
  parameter int DUTY_MAX     = 3800,
  parameter int SHIFT        = 7,
  parameter int DEAD_PERIODS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] delta,
  input  logic        clear,
  output logic        pwm,
  output logic        dir,
  output logic [15:0] duty,
  output logic        sat
);

  localparam int DW = $clog2(DEAD_PERIODS + 1);
  localparam logic [15:0]        CNT_TERM  = 16'(PERIOD);
  localparam logic signed [32:0] ACC_HI    = $signed(33'(DUTY_MAX));
  localparam logic signed [32:0] ACC_LO    = -ACC_HI;
  localparam logic [DW-1:0]      DEAD_INIT = DW'(DEAD_PERIODS);
  localparam logic [DW-1:0]      DEAD_ONE  = DW'(1);

  typedef enum logic {RUN, DEAD} state_t;

  logic signed [31:0] acc, acc_next;
  logic signed [31:0] delta_sh;
  logic signed [32:0] sum;
  logic               sat_next;
  logic [15:0]        cnt, cnt_next;
  logic               boundary;
  logic [15:0]        mag;
  logic               sgn;
  state_t             state_q, state_next;
  logic [DW-1:0]      dead_cnt, dead_next;
  logic [15:0]        duty_next;
  logic               dir_next;
  logic               pwm_next;

  // Accumulator update: clear wins over enable; the sum is one bit wider so
  // it cannot wrap before the clamp compares it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    acc_next = acc;
    sat_next = sat;
    delta_sh = $signed(delta) >>> SHIFT;
    sum      = $signed({acc[31], acc}) + $signed({delta_sh[31], delta_sh});
    if (clear) begin
      acc_next = '0;
      sat_next = 1'b0;
    end else if (enable) begin
      if (sum > ACC_HI) begin
        acc_next = ACC_HI[31:0];
        sat_next = 1'b1;
      end else if (sum < ACC_LO) begin
        acc_next = ACC_LO[31:0];
        sat_next = 1'b1;
      end else begin
        acc_next = sum[31:0];
        sat_next = 1'b0;
      end
    end
  end

  // Free-running period counter and magnitude/sign of the current accumulator.
  // |acc| never exceeds DUTY_MAX, so the low 16 bits hold it exactly.
  always_comb begin
    boundary = (cnt == CNT_TERM);
    cnt_next = boundary ? 16'd0 : cnt + 16'd1;
    sgn      = acc[31];
    mag      = acc[31] ? 16'(-acc[15:0]) : acc[15:0];
  end

  // Direction/dead-time FSM, acting only at period boundaries, plus the next
  // PWM level computed from the duty that will be in force next cycle.
  always_comb begin
    state_next = state_q;
    dead_next  = dead_cnt;
    duty_next  = duty;
    dir_next   = dir;
    if (boundary) begin
      unique case (state_q)
        RUN: begin
          if (mag == 16'd0) begin
            duty_next = 16'd0;
          end else if (sgn == dir) begin
            duty_next = mag;
          end else begin
            duty_next  = 16'd0;
            dead_next  = DEAD_INIT;
            state_next = DEAD;
          end
        end
        DEAD: begin
          if (dead_cnt <= DEAD_ONE) begin
            dead_next  = '0;
            state_next = RUN;
            duty_next  = mag;
            if ((mag != 16'd0) && (sgn != dir)) dir_next = sgn;
          end else begin
            dead_next = dead_cnt - DEAD_ONE;
          end
        end
        default: state_next = RUN;
      endcase
    end
    pwm_next = (state_next == RUN) && (cnt_next < duty_next);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: state is assigned with <= so every register samples pre-edge
    // values regardless of statement order.
    if (rst) begin
      acc      <= '0;
      sat      <= 1'b0;
      cnt      <= '0;
      state_q  <= RUN;
      dead_cnt <= '0;
      duty     <= '0;
      dir      <= 1'b0;
      pwm      <= 1'b0;
    end else begin
      acc      <= acc_next;
      sat      <= sat_next;
      cnt      <= cnt_next;
      state_q  <= state_next;
      dead_cnt <= dead_next;
      duty     <= duty_next;
      dir      <= dir_next;
      pwm      <= pwm_next;
    end
  end

endmodule

// File: tb/tb_pi_pwm_drive.sv
// Self-checking bench for pi_pwm_drive: an integer-level model of the
// accumulator, period timing and dead-time rules is compared against the DUT
// on every falling edge, with hand-computed expectations along the way.
module tb_pi_pwm_drive;

  localparam int PERIOD       = 3999;
  localparam int DUTY_MAX     = 3800;
  localparam int SHIFT        = 7;
  localparam int DEAD_PERIODS = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] delta;
  logic        clear;
  logic        pwm;
  logic        dir;
  logic [15:0] duty;
  logic        sat;

  int checks = 0;
  int errors = 0;
  bit done   = 0;

  pi_pwm_drive #(
    .PERIOD(PERIOD), .DUTY_MAX(DUTY_MAX), .SHIFT(SHIFT), .DEAD_PERIODS(DEAD_PERIODS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .delta(delta), .clear(clear),
    .pwm(pwm), .dir(dir), .duty(duty), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic finish_run();
    if (!done) begin
      done = 1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      if (errors >= 50) finish_run();
    end
  endtask

  // Behavioural model: plain integers, one step per rising edge.
  int m_acc = 0, m_cnt = 0, m_duty = 0, m_dead_left = 0;
  bit m_dir = 0, m_pwm = 0, m_sat = 0;
  bit started = 0;

  always @(posedge clk) begin : model
    int mag;
    int sum;
    bit sgn;
    started = 1;
    if (rst) begin
      m_acc = 0; m_cnt = 0; m_duty = 0; m_dead_left = 0;
      m_dir = 0; m_pwm = 0; m_sat = 0;
    end else begin
      if (m_cnt == PERIOD) begin
        mag = (m_acc < 0) ? -m_acc : m_acc;
        sgn = (m_acc < 0);
        if (m_dead_left == 0) begin
          if (mag == 0)            m_duty = 0;
          else if (sgn == m_dir)   m_duty = mag;
          else begin
            m_duty      = 0;
            m_dead_left = DEAD_PERIODS;
          end
        end else begin
          m_dead_left--;
          if (m_dead_left == 0) begin
            if (mag != 0 && sgn != m_dir) m_dir = sgn;
            m_duty = mag;
          end
        end
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      if (clear) begin
        m_acc = 0;
        m_sat = 0;
      end else if (enable) begin
        sum = m_acc + ($signed(delta) >>> SHIFT);
        if (sum > DUTY_MAX)       begin m_acc = DUTY_MAX;  m_sat = 1; end
        else if (sum < -DUTY_MAX) begin m_acc = -DUTY_MAX; m_sat = 1; end
        else                      begin m_acc = sum;       m_sat = 0; end
      end
      m_pwm = (m_dead_left == 0) && (m_cnt < m_duty);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (started && !done)
      check("outputs{pwm,dir,duty,sat}", {13'd0, pwm, dir, duty, sat},
            {13'd0, m_pwm, m_dir, 16'(m_duty), m_sat});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_en(input int d);
    enable = 1'b1;
    delta  = d;
    tick();
    enable = 1'b0;
    delta  = '0;
  endtask

  // Advance to the first cycle of the next period.
  task automatic goto_start();
    for (int i = 0; i <= PERIOD + 1; i++) begin
      tick();
      if (m_cnt == 0) return;
    end
    errors++;
    $display("FAIL goto_start timeout at %0t", $time);
  endtask

  task automatic goto_cnt(input int v);
    for (int i = 0; i <= PERIOD + 1; i++) begin
      tick();
      if (m_cnt == v) return;
    end
    errors++;
    $display("FAIL goto_cnt timeout at %0t", $time);
  endtask

  // Count PWM-high cycles over one full period, starting at a period start.
  task automatic count_high(output int n);
    n = 0;
    for (int i = 0; i <= PERIOD; i++) begin
      if (pwm === 1'b1) n++;
      tick();
    end
  endtask

  initial begin : watchdog
    #1_500_000;
    errors++;
    $display("FAIL watchdog expired at %0t", $time);
    finish_run();
  end

  initial begin : stimulus
    int n;
    rst = 1'b1; enable = 1'b0; clear = 1'b0; delta = '0;
    repeat (2) tick();
    rst = 1'b0;

    // 1: idle after reset, three periods of constant low.
    check("reset_duty", duty, 0);
    check("reset_sat", sat, 0);
    for (int p = 0; p < 3; p++) begin
      count_high(n);
      check("idle_pwm_high", n, 0);
    end
    check("idle_dir", dir, 0);

    // 2: single step, 128000 >>> 7 = 1000.
    pulse_en(128000);
    check("step_sat", sat, 0);
    goto_start();
    check("step_duty", duty, 1000);
    check("step_dir", dir, 0);
    check("step_pwm_first", pwm, 1);
    count_high(n);
    check("step_pwm_high", n, 1000);
    check("step_pwm_wrap", pwm, 1);

    // 3: saturation at +3800, then back off by 100.
    repeat (4) pulse_en(128000);
    check("sat_high", sat, 1);
    goto_start();
    check("sat_duty", duty, 3800);
    pulse_en(-12800);
    check("unsat", sat, 0);
    goto_start();
    check("unsat_duty", duty, 3700);
    pulse_en(-345600);
    goto_start();
    check("back_duty", duty, 1000);

    // 4: reversal to acc=-1000 with one dead period.
    pulse_en(-256000);
    goto_start();
    check("rev_dead_duty", duty, 0);
    check("rev_dead_dir", dir, 0);
    count_high(n);
    check("rev_dead_pwm_high", n, 0);
    check("rev_dir", dir, 1);
    check("rev_duty", duty, 1000);

    // 5: reversal cancelled inside the dead period.
    pulse_en(256000);
    goto_start();
    check("cancel_dead_duty", duty, 0);
    pulse_en(-256000);
    goto_start();
    check("cancel_dir", dir, 1);
    check("cancel_duty", duty, 1000);

    // 6: reverse to acc=2000, then clear together with enable.
    pulse_en(384000);
    goto_start();
    goto_start();
    check("fwd_dir", dir, 0);
    check("fwd_duty", duty, 2000);
    clear = 1'b1;
    pulse_en(128000);
    clear = 1'b0;
    check("clear_sat", sat, 0);
    goto_start();
    check("clear_duty", duty, 0);
    check("clear_pwm", pwm, 0);
    check("clear_dir", dir, 0);

    // Enable coincident with boundary: boundary sees the old acc of 0.
    goto_cnt(PERIOD);
    pulse_en(128000);
    check("coinc_duty_old", duty, 0);
    goto_start();
    check("coinc_duty_new", duty, 1000);

    // Negative clamp, then reset mid-period.
    pulse_en(-1000000000);
    check("sat_low", sat, 1);
    repeat (500) tick();
    check("mid_pwm", pwm, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_pwm", pwm, 0);
    check("rst_duty", duty, 0);
    check("rst_sat", sat, 0);
    check("rst_dir", dir, 0);
    repeat (100) tick();
    finish_run();
  end

endmodule
